data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MEM pipeline stage and the word-addressed data memory. Read hits return data in the same cycle. A read miss raises `stall` and refills a 4-word line from memory. Stores are forwarded to memory in the same cycle and update the cache only on a hit.

---
 rtl/data_cache_pkg.sv | 17 +
 rtl/data_cache_if.sv | 29 ++
 rtl/data_cache_array.sv | 53 +++++
 rtl/data_cache.sv | 165 ++++++++++++++++
 tb/tb_data_cache.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/data_cache_pkg.sv
// Shared constants and FSM state encoding for the direct-mapped data cache.
package data_cache_pkg;

  localparam int DC_WORD_LEN    = 32;
  localparam int DC_ADDRESS_LEN = 32;
  localparam int DC_LINES       = 64;
  localparam int DC_BLOCK_WORDS = 4;
  localparam int DC_OFF_W       = $clog2(DC_BLOCK_WORDS);
  localparam int DC_IDX_W       = $clog2(DC_LINES);
  localparam int DC_TAG_W       = DC_ADDRESS_LEN - DC_IDX_W - DC_OFF_W;

  typedef enum logic [0:0] {
    DC_IDLE   = 1'b0,
    DC_REFILL = 1'b1
  } dc_state_e;

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle of the data cache; the cache is the slave.
interface data_cache_if
  import data_cache_pkg::*;
#(
  parameter int WORD_LEN    = DC_WORD_LEN,
  parameter int ADDRESS_LEN = DC_ADDRESS_LEN
);
  logic [ADDRESS_LEN-1:0] cpu_adr;
  logic [WORD_LEN-1:0]    cpu_write_data;
  logic                   cpu_read;
  logic                   cpu_write;
  logic [WORD_LEN-1:0]    cpu_read_data;
  logic                   stall;
  logic [ADDRESS_LEN-1:0] mem_adr;
  logic [WORD_LEN-1:0]    mem_write_data;
  logic                   mem_read;
  logic                   mem_write;
  logic [WORD_LEN-1:0]    mem_read_data;

  modport slave (
    input  cpu_adr, cpu_write_data, cpu_read, cpu_write, mem_read_data,
    output cpu_read_data, stall, mem_adr, mem_write_data, mem_read, mem_write
  );

  modport master (
    output cpu_adr, cpu_write_data, cpu_read, cpu_write, mem_read_data,
    input  cpu_read_data, stall, mem_adr, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/data_cache_array.sv
// Valid/tag/data storage: combinational read port, synchronous word write,
// valid bits cleared asynchronously by reset (data and tags are never cleared).
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int WORD_LEN    = DC_WORD_LEN,
  parameter int LINES       = DC_LINES,
  parameter int BLOCK_WORDS = DC_BLOCK_WORDS,
  parameter int IDX_W       = DC_IDX_W,
  parameter int OFF_W       = DC_OFF_W,
  parameter int TAG_W       = DC_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic [OFF_W-1:0]    rd_off,
  output logic [WORD_LEN-1:0] rd_data,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [OFF_W-1:0]    wr_off,
  input  logic [WORD_LEN-1:0] wr_data,
  input  logic                inval,
  input  logic                fill_done,
  input  logic [TAG_W-1:0]    fill_tag
);

  logic [WORD_LEN-1:0] data_mem [LINES*BLOCK_WORDS];
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [LINES-1:0]    valid_q, valid_d;

  assign rd_data  = data_mem[{rd_idx, rd_off}];
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];

  always_comb begin
    valid_d = valid_q;
    if (inval)     valid_d[wr_idx] = 1'b0;
    if (fill_done) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en)     data_mem[{wr_idx, wr_off}] <= wr_data;
    if (fill_done) tag_mem[wr_idx]            <= fill_tag;
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with IDLE/REFILL FSM.
// Optional DATA_CACHE_STATS_EN adds 32-bit hit_count/miss_count outputs.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int WORD_LEN    = DC_WORD_LEN,
  parameter int ADDRESS_LEN = DC_ADDRESS_LEN,
  parameter int LINES       = DC_LINES,
  parameter int BLOCK_WORDS = DC_BLOCK_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  data_cache_if.slave bus
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDRESS_LEN - IDX_W - OFF_W;

  logic [OFF_W-1:0] cpu_off;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;

  assign cpu_off = bus.cpu_adr[OFF_W-1:0];
  assign cpu_idx = bus.cpu_adr[OFF_W +: IDX_W];
  assign cpu_tag = bus.cpu_adr[ADDRESS_LEN-1 -: TAG_W];

  dc_state_e        state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0] miss_idx_q, miss_idx_d;

  logic [WORD_LEN-1:0] rd_data;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic                hit;
  logic                arr_we, arr_inval, arr_fill;
  logic [IDX_W-1:0]    arr_idx;
  logic [OFF_W-1:0]    arr_off;
  logic [WORD_LEN-1:0] arr_wdata;

  assign hit               = rd_valid && (rd_tag == cpu_tag);
  assign bus.cpu_read_data = rd_data;

  data_cache_array #(
    .WORD_LEN   (WORD_LEN),
    .LINES      (LINES),
    .BLOCK_WORDS(BLOCK_WORDS),
    .IDX_W      (IDX_W),
    .OFF_W      (OFF_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (cpu_idx),
    .rd_off   (cpu_off),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .wr_en    (arr_we),
    .wr_idx   (arr_idx),
    .wr_off   (arr_off),
    .wr_data  (arr_wdata),
    .inval    (arr_inval),
    .fill_done(arr_fill),
    .fill_tag (miss_tag_q)
  );

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    miss_tag_d         = miss_tag_q;
    miss_idx_d         = miss_idx_q;
    bus.stall          = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_adr        = bus.cpu_adr;
    bus.mem_write_data = bus.cpu_write_data;
    arr_we             = 1'b0;
    arr_inval          = 1'b0;
    arr_fill           = 1'b0;
    arr_idx            = cpu_idx;
    arr_off            = cpu_off;
    arr_wdata          = bus.cpu_write_data;
    unique case (state_q)
      DC_IDLE: begin
        // A store wins over a simultaneous load; the cached copy only follows on a hit.
        if (bus.cpu_write) begin
          bus.mem_write = 1'b1;
          arr_we        = hit;
        end else if (bus.cpu_read && !hit) begin
          bus.stall  = 1'b1;
          arr_inval  = 1'b1;
          miss_tag_d = cpu_tag;
          miss_idx_d = cpu_idx;
          cnt_d      = '0;
          state_d    = DC_REFILL;
        end
      end
      DC_REFILL: begin
        bus.stall    = 1'b1;
        bus.mem_read = 1'b1;
        bus.mem_adr  = {miss_tag_q, miss_idx_q, cnt_q};
        arr_we       = 1'b1;
        arr_idx      = miss_idx_q;
        arr_off      = cnt_q;
        arr_wdata    = bus.mem_read_data;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == OFF_W'(BLOCK_WORDS - 1)) begin
          arr_fill = 1'b1;
          state_d  = DC_IDLE;
        end
      end
      default: state_d = DC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DC_IDLE;
      cnt_q      <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Loads only; the completing cycle of a miss is itself counted as a hit.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == DC_IDLE && bus.cpu_read && !bus.cpu_write) begin
      if (hit) hit_count_d  = hit_count_q + 32'd1;
      else     miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, reset corner cases,
// and randomized loads/stores against a block-residency reference model.
module tb_data_cache;

  localparam int MEMW = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_cache_if #(.WORD_LEN(32), .ADDRESS_LEN(32)) bus ();

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache #(
    .WORD_LEN   (32),
    .ADDRESS_LEN(32),
    .LINES      (64),
    .BLOCK_WORDS(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // Word-addressed backing memory with a preload port.
  logic [31:0] mem [MEMW];
  logic        ld_en = 1'b0;
  logic [11:0] ld_adr = '0;
  logic [31:0] ld_data = '0;

  assign bus.mem_read_data = mem[int'(bus.mem_adr % 32'(MEMW))];

  always @(posedge clk) begin
    if (ld_en)              mem[ld_adr] <= ld_data;
    else if (bus.mem_write) mem[int'(bus.mem_adr % 32'(MEMW))] <= bus.mem_write_data;
  end

  // Reference model: expected memory contents and which block each line holds.
  logic [31:0] ref_mem [MEMW];
  bit          m_vld [64];
  int unsigned m_blk [64];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
  endfunction

  function automatic int model_load(input logic [31:0] a);
    int unsigned blk = a / 4;
    int unsigned idx = blk % 64;
    int st = (m_vld[idx] && m_blk[idx] == blk) ? 0 : 5;
    m_vld[idx] = 1'b1;
    m_blk[idx] = blk;
    return st;
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic also_read);
    @(negedge clk);
    bus.cpu_adr = a; bus.cpu_write_data = d; bus.cpu_write = 1'b1; bus.cpu_read = also_read;
    #1;
    check("st_stall", 32'(bus.stall), 32'd0);
    check("st_mem_write", 32'(bus.mem_write), 32'd1);
    check("st_mem_adr", bus.mem_adr, a);
    check("st_mem_wdata", bus.mem_write_data, d);
    @(posedge clk); #1;
    bus.cpu_write = 1'b0; bus.cpu_read = 1'b0;
    ref_mem[int'(a % 32'(MEMW))] = d;
    check("st_commit", mem[int'(a % 32'(MEMW))], d);
  endtask

  task automatic do_load(input logic [31:0] a, input int exp_st, input logic [31:0] exp_d);
    int st = 0;
    logic [31:0] adrs[$];
    @(negedge clk);
    bus.cpu_adr = a; bus.cpu_read = 1'b1; bus.cpu_write = 1'b0;
    #1;
    while (bus.stall && st < 20) begin
      if (bus.mem_read) adrs.push_back(bus.mem_adr);
      st++;
      @(negedge clk); #1;
    end
    check("ld_stall_cycles", 32'(st), 32'(exp_st));
    check("ld_data", bus.cpu_read_data, exp_d);
    check("ld_mem_read_after", 32'(bus.mem_read), 32'd0);
    if (exp_st != 0) begin
      check("refill_words", 32'(adrs.size()), 32'd4);
      for (int k = 0; k < adrs.size() && k < 4; k++)
        check("refill_adr", adrs[k], (a & ~32'd3) + 32'(k));
    end
    @(posedge clk); #1;
    bus.cpu_read = 1'b0;
  endtask

  typedef struct {
    int          op;     // 0 load, 1 store, 2 store+load together
    logic [31:0] adr;
    logic [31:0] wdata;
    int          exp_st;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_adr = '0; bus.cpu_write_data = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;

    tbl[0] = '{0, 32'd1001, 32'd0,  5, 32'd20};
    tbl[1] = '{0, 32'd1003, 32'd0,  0, 32'd100};
    tbl[2] = '{1, 32'd1002, 32'd55, 0, 32'd0};
    tbl[3] = '{0, 32'd1002, 32'd0,  0, 32'd55};
    tbl[4] = '{2, 32'd1003, 32'd77, 0, 32'd0};
    tbl[5] = '{0, 32'd1003, 32'd0,  0, 32'd77};
    tbl[6] = '{1, 32'd2000, 32'd9,  0, 32'd0};
    tbl[7] = '{0, 32'd2000, 32'd0,  5, 32'd9};
    tbl[8] = '{0, 32'd1256, 32'd0,  5, 32'd31};
    tbl[9] = '{0, 32'd1000, 32'd0,  5, 32'd7};

    // Preload memory while the cache is held in reset.
    for (int i = 0; i < MEMW; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (i >= 1000 && i <= 1003) v = (i == 1000) ? 32'd7 : (i == 1001) ? 32'd20 :
                                      (i == 1002) ? 32'd200 : 32'd100;
      if (i >= 1256 && i <= 1259) v = 32'(31 + i - 1256);
      @(negedge clk);
      ld_en = 1'b1; ld_adr = 12'(i); ld_data = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].op == 0) begin
        void'(model_load(tbl[i].adr));
        do_load(tbl[i].adr, tbl[i].exp_st, tbl[i].exp_d);
      end else begin
        do_store(tbl[i].adr, tbl[i].wdata, tbl[i].op == 2);
      end
`ifdef DATA_CACHE_STATS_EN
      if (i == 1) begin
        check("hit_count", hit_count, 32'd2);
        check("miss_count", miss_count, 32'd1);
      end
`endif
    end

    // Reset during the third refill cycle, then the same load refills in full.
    @(negedge clk);
    bus.cpu_adr = 32'd3000; bus.cpu_read = 1'b1;
    #1;
    check("mid_first_stall", 32'(bus.stall), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("mid_refill_read", 32'(bus.mem_read), 32'd1);
    check("mid_refill_adr", bus.mem_adr, 32'd3002);
    rst = 1'b0; bus.cpu_read = 1'b0;
    #1;
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_mem_read", 32'(bus.mem_read), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    void'(model_load(32'd3000));
    do_load(32'd3000, 5, ref_mem[3000]);

    // Randomized traffic concentrated on a few indices to force conflicts.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 3) * 256 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 99) < 35) begin
        do_store(a, $urandom, $urandom_range(0, 1) == 1);
      end else begin
        int est;
        est = model_load(a);
        do_load(a, est, ref_mem[int'(a)]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
